// File: rtl/spart_echo_ctrl.sv
// -----------------------------------------------------------------------------
// spart_echo_ctrl
//   Drives the SPART register bus: programs the baud divisor selected by the
//   board switches, drains received bytes into a small circular FIFO and
//   echoes them back in arrival order whenever the transmitter is ready.
//   A change on br_cfg reprograms the divisor without touching the FIFO.
//
// Ports
//   clk         system clock, all logic on its rising edge
//   rst         synchronous, active-high reset
//   br_cfg      baud select: 00=4800, 01=9600, 10=19200, 11=38400
//   rda         SPART receive data available
//   tbr         SPART transmit buffer ready
//   iocs        SPART chip select (one bus cycle = one clk with iocs=1)
//   iorw        1=read, 0=write
//   ioaddr      00=RX/TX buffer, 10=divisor low, 11=divisor high
//   databus     SPART data bus, driven only during write cycles
//   init_done   divisor programmed and block running
//   fifo_count  bytes currently buffered
//   fifo_full   fifo_count == FIFO_DEPTH
//
// FIFO_DEPTH must be a power of two and at least 2 so the pointers wrap
// naturally at their own width.
// -----------------------------------------------------------------------------
module spart_echo_ctrl #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  br_cfg,
    input  logic                        rda,
    input  logic                        tbr,
    output logic                        iocs,
    output logic                        iorw,
    output logic [1:0]                  ioaddr,
    inout  wire  [7:0]                  databus,
    output logic                        init_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        fifo_full
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Divisors are fixed at elaboration from the clock frequency.
    localparam logic [15:0] DIV_4800  = 16'(CLK_HZ / (OVS * 4800)  - 1);
    localparam logic [15:0] DIV_9600  = 16'(CLK_HZ / (OVS * 9600)  - 1);
    localparam logic [15:0] DIV_19200 = 16'(CLK_HZ / (OVS * 19200) - 1);
    localparam logic [15:0] DIV_38400 = 16'(CLK_HZ / (OVS * 38400) - 1);

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT_LO = 3'd1,
        ST_INIT_HI = 3'd2,
        ST_RUN     = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    function automatic logic [15:0] div_sel(input logic [1:0] sel);
        case (sel)
            2'b00:   div_sel = DIV_4800;
            2'b01:   div_sel = DIV_9600;
            2'b10:   div_sel = DIV_19200;
            2'b11:   div_sel = DIV_38400;
            default: div_sel = DIV_4800;
        endcase
    endfunction

    function automatic logic [7:0] div_byte(input logic [1:0] sel, input logic hi);
        logic [15:0] d;
        d = div_sel(sel);
        div_byte = hi ? d[15:8] : d[7:0];
    endfunction

    state_t        state_r;
    logic [1:0]    shadow_r;
    logic          iocs_r;
    logic          iorw_r;
    logic [1:0]    ioaddr_r;
    logic          oe_r;
    logic [7:0]    dout_r;
    logic          init_done_r;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_r;

    logic [7:0]    div_lo_new_s;
    logic [7:0]    div_hi_cur_s;
    logic          bus_done_s;
    logic          push_s;
    logic          pop_s;
    logic          empty_s;
    logic [7:0]    head_s;

    // Divisor bytes, FIFO head and the push/pop strobes for the bus cycle now ending.
    // A buffer access is commanded from RUN and is on the pins while the FSM
    // sits in GAP, so the transfer completes on the edge that leaves GAP.
    always_comb begin
        div_lo_new_s = div_byte(br_cfg, 1'b0);
        div_hi_cur_s = div_byte(shadow_r, 1'b1);
        bus_done_s   = (state_r == ST_GAP) && iocs_r;
        push_s       = bus_done_s && iorw_r;
        pop_s        = bus_done_s && !iorw_r;
        empty_s      = (count_r == {CW{1'b0}});
        head_s       = mem_r[rd_ptr_r];
    end

    // Control FSM with registered bus outputs: each transition loads the
    // pin values for the cycle that follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            shadow_r    <= 2'b00;
            iocs_r      <= 1'b0;
            iorw_r      <= 1'b1;
            ioaddr_r    <= ADDR_BUF;
            oe_r        <= 1'b0;
            dout_r      <= 8'h00;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    shadow_r <= br_cfg;
                    state_r  <= ST_INIT_LO;
                    iocs_r   <= 1'b1;
                    iorw_r   <= 1'b0;
                    ioaddr_r <= ADDR_DIV_LO;
                    oe_r     <= 1'b1;
                    dout_r   <= div_lo_new_s;
                end
                ST_INIT_LO: begin
                    state_r  <= ST_INIT_HI;
                    iocs_r   <= 1'b1;
                    iorw_r   <= 1'b0;
                    ioaddr_r <= ADDR_DIV_HI;
                    oe_r     <= 1'b1;
                    dout_r   <= div_hi_cur_s;
                end
                ST_INIT_HI: begin
                    state_r     <= ST_GAP;
                    iocs_r      <= 1'b0;
                    iorw_r      <= 1'b1;
                    ioaddr_r    <= ADDR_BUF;
                    oe_r        <= 1'b0;
                    init_done_r <= 1'b1;
                end
                ST_GAP: begin
                    // Release the bus; RUN then idles the pins for at least one cycle.
                    state_r  <= ST_RUN;
                    iocs_r   <= 1'b0;
                    iorw_r   <= 1'b1;
                    ioaddr_r <= ADDR_BUF;
                    oe_r     <= 1'b0;
                end
                ST_RUN: begin
                    if (br_cfg != shadow_r) begin
                        state_r     <= ST_IDLE;
                        init_done_r <= 1'b0;
                        iocs_r      <= 1'b0;
                        iorw_r      <= 1'b1;
                        ioaddr_r    <= ADDR_BUF;
                        oe_r        <= 1'b0;
                    end else if (rda && !full_r) begin
                        // Receive first: draining the SPART beats echoing.
                        state_r  <= ST_GAP;
                        iocs_r   <= 1'b1;
                        iorw_r   <= 1'b1;
                        ioaddr_r <= ADDR_BUF;
                        oe_r     <= 1'b0;
                    end else if (tbr && !empty_s) begin
                        state_r  <= ST_GAP;
                        iocs_r   <= 1'b1;
                        iorw_r   <= 1'b0;
                        ioaddr_r <= ADDR_BUF;
                        oe_r     <= 1'b1;
                        dout_r   <= head_s;
                    end else begin
                        state_r  <= ST_RUN;
                        iocs_r   <= 1'b0;
                        iorw_r   <= 1'b1;
                        ioaddr_r <= ADDR_BUF;
                        oe_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    init_done_r <= 1'b0;
                    iocs_r      <= 1'b0;
                    iorw_r      <= 1'b1;
                    ioaddr_r    <= ADDR_BUF;
                    oe_r        <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and full flag; push and pop are mutually exclusive.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
        end else if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            count_r  <= count_r + CNT_ONE;
            full_r   <= (count_r == CNT_LAST);
        end else if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r  <= count_r - CNT_ONE;
            full_r   <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_r;
            rd_ptr_r <= rd_ptr_r;
            count_r  <= count_r;
            full_r   <= full_r;
        end
    end

    // FIFO storage: capture the byte the SPART drives on a completed read.
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            mem_r[wr_ptr_r] <= databus;
        end
    end

    assign databus    = oe_r ? dout_r : 8'hzz;
    assign iocs       = iocs_r;
    assign iorw       = iorw_r;
    assign ioaddr     = ioaddr_r;
    assign init_done  = init_done_r;
    assign fifo_count = count_r;
    assign fifo_full  = full_r;

endmodule

// File: tb/tb_spart_echo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spart_echo_ctrl
//   Self-checking bench for spart_echo_ctrl. A small SPART model offers bytes
//   from an array (rda while unread bytes remain) and drives them on reads.
//   The reference model is the stream itself: every echoed byte must be the
//   next byte the block accepted, the occupancy is reads minus writes, and the
//   divisor bytes follow floor(CLK_HZ/(OVS*baud))-1.
// -----------------------------------------------------------------------------
module tb_spart_echo_ctrl;

    localparam int CLK_HZ = 50_000_000;
    localparam int OVS    = 16;
    localparam int DEPTH  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       tbr;
    logic       rda_en;
    wire        rda;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       init_done;
    logic [3:0] fifo_count;
    logic       fifo_full;

    int n_checks = 0;
    int n_errors = 0;

    // SPART model state
    logic [7:0] rx_arr [256];
    int         rx_n   = 0;
    int         rx_idx = 0;
    int         rd_cnt = 0;
    int         wr_idx = 0;
    int         div_n  = 0;
    logic       pend_rd   = 1'b0;
    logic       prev_iocs = 1'b0;
    logic [1:0] prev_addr = 2'b00;
    logic       prev_rw   = 1'b1;
    logic [1:0] br_q;
    logic [1:0] lo_br = 2'b00;
    logic       mark_armed = 1'b0;
    int         first_kind = 0;

    spart_echo_ctrl #(.CLK_HZ(CLK_HZ), .OVS(OVS), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .rda        (rda),
        .tbr        (tbr),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus    (databus),
        .init_done  (init_done),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full)
    );

    always #5 clk = ~clk;

    assign rda     = rda_en && (rx_idx < rx_n);
    assign databus = (iocs && iorw && ioaddr == 2'b00) ? rx_arr[rx_idx % 256] : 8'hzz;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] div_of(input logic [1:0] br);
        int baud;
        baud = 4800 << br;
        return 16'(CLK_HZ / (OVS * baud) - 1);
    endfunction

    // Two-state simulators show a released bus as zero.
    function automatic logic bus_released();
        return (databus === 8'hzz) || (databus === 8'h00);
    endfunction

    // br_cfg as the DUT saw it on the most recent rising edge.
    always @(posedge clk) br_q <= br_cfg;

    // Bus monitor and reference model, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        int cnt_m;
        logic [15:0] d;
        if (rst) begin
            if (pend_rd) rx_idx = rx_idx + 1;
            pend_rd   = 1'b0;
            rd_cnt    = rx_idx;
            wr_idx    = rx_idx;
            prev_iocs = 1'b0;
        end else begin
            if (pend_rd) begin
                rx_idx  = rx_idx + 1;
                pend_rd = 1'b0;
            end
            cnt_m = rd_cnt - wr_idx;
            chk_val("count", 32'(fifo_count), cnt_m);
            chk_val("full", 32'(fifo_full), 32'(cnt_m == DEPTH));
            if (!iocs) chk_val("hiz", 32'(bus_released()), 1);
            if (iocs) begin
                if (prev_iocs)
                    chk_val("gap", 32'(prev_addr == 2'b10 && !prev_rw && ioaddr == 2'b11), 1);
                if (iorw) begin
                    chk_val("rd_addr", 32'(ioaddr), 0);
                    chk_val("rd_avail", 32'(rx_idx < rx_n), 1);
                    chk_val("rd_room", 32'(cnt_m < DEPTH), 1);
                    chk_val("rd_init", 32'(init_done), 1);
                    rd_cnt  = rd_cnt + 1;
                    pend_rd = 1'b1;
                    if (mark_armed) begin first_kind = 1; mark_armed = 1'b0; end
                end else begin
                    case (ioaddr)
                        2'b00: begin
                            chk_val("wr_nonempty", 32'(cnt_m > 0), 1);
                            chk_val("echo", 32'(databus), 32'(rx_arr[wr_idx % 256]));
                            chk_val("wr_init", 32'(init_done), 1);
                            wr_idx = wr_idx + 1;
                            if (mark_armed) begin first_kind = 2; mark_armed = 1'b0; end
                        end
                        2'b10: begin
                            lo_br = br_q;
                            d = div_of(br_q);
                            chk_val("div_lo", 32'(databus), 32'(d[7:0]));
                            chk_val("div_lo_init", 32'(init_done), 0);
                            div_n = div_n + 1;
                        end
                        2'b11: begin
                            d = div_of(lo_br);
                            chk_val("div_hi", 32'(databus), 32'(d[15:8]));
                            chk_val("div_hi_init", 32'(init_done), 0);
                            div_n = div_n + 1;
                        end
                        default: chk_val("wr_addr", 32'(ioaddr), 0);
                    endcase
                end
            end
            prev_iocs = iocs;
            prev_addr = ioaddr;
            prev_rw   = iorw;
        end
    end

    task automatic offer(input logic [7:0] b);
        rx_arr[rx_n % 256] = b;
        rx_n = rx_n + 1;
    endtask

    task automatic wait_cnt(input string tag, input int target);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (32'(fifo_count) == target) break;
        end
        chk_val(tag, 32'(fifo_count), target);
    endtask

    task automatic wait_drained(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (wr_idx == rx_n) break;
        end
        chk_val(tag, wr_idx, rx_n);
    endtask

    task automatic wait_init(input string tag, input logic val);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (init_done == val) break;
        end
        chk_val(tag, 32'(init_done), 32'(val));
    endtask

    initial begin
        int div_n0;
        rst = 1'b1; br_cfg = 2'b01; tbr = 1'b0; rda_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_val("rst_iocs", 32'(iocs), 0);
        chk_val("rst_iorw", 32'(iorw), 1);
        chk_val("rst_addr", 32'(ioaddr), 0);
        chk_val("rst_bus", 32'(bus_released()), 1);
        chk_val("rst_done", 32'(init_done), 0);
        chk_val("rst_cnt", 32'(fifo_count), 0);
        chk_val("rst_full", 32'(fifo_full), 0);

        // Init sequence at 9600 baud: 0x0144
        rst = 1'b0;
        @(negedge clk); #1;
        chk_val("ilo_cs", 32'(iocs), 1);
        chk_val("ilo_rw", 32'(iorw), 0);
        chk_val("ilo_addr", 32'(ioaddr), 2);
        chk_val("ilo_data", 32'(databus), 32'h44);
        @(negedge clk); #1;
        chk_val("ihi_cs", 32'(iocs), 1);
        chk_val("ihi_addr", 32'(ioaddr), 3);
        chk_val("ihi_data", 32'(databus), 32'h01);
        @(negedge clk); #1;
        chk_val("init_done", 32'(init_done), 1);
        chk_val("post_cs", 32'(iocs), 0);
        chk_val("post_bus", 32'(bus_released()), 1);

        // Single echo
        offer(8'h5A); rda_en = 1'b1; tbr = 1'b1;
        wait_cnt("single_cnt1", 1);
        wait_drained("single_echo");
        wait_cnt("single_cnt0", 0);

        // Burst of 9 with the transmitter busy
        tbr = 1'b0;
        for (int i = 1; i <= 9; i++) offer(8'(i));
        wait_cnt("burst_cnt", DEPTH);
        repeat (20) @(negedge clk);
        #1;
        chk_val("burst_full", 32'(fifo_full), 1);
        chk_val("burst_held", rx_n - rx_idx, 1);
        tbr = 1'b1;
        wait_drained("burst_echo");

        // Priority: read beats write
        tbr = 1'b0;
        for (int i = 0; i < 3; i++) offer(8'($urandom));
        wait_cnt("prio_cnt", 3);
        rda_en = 1'b0;
        offer(8'($urandom));
        @(negedge clk); #1;
        mark_armed = 1'b1; rda_en = 1'b1; tbr = 1'b1;
        for (int i = 0; i < 20 && mark_armed; i++) begin @(negedge clk); #1; end
        chk_val("prio_first", first_kind, 1);
        wait_drained("prio_echo");

        // Reconfigure with two bytes buffered
        tbr = 1'b0;
        offer(8'hA1); offer(8'hB2);
        wait_cnt("cfg_cnt", 2);
        div_n0 = div_n;
        br_cfg = 2'b11;
        wait_init("cfg_drop", 1'b0);
        wait_init("cfg_rise", 1'b1);
        chk_val("cfg_divs", div_n, div_n0 + 2);
        chk_val("cfg_keep", 32'(fifo_count), 2);
        tbr = 1'b1;
        wait_drained("cfg_echo");

        // Reset during a write cycle
        tbr = 1'b0;
        offer(8'hC3); offer(8'hD4);
        wait_cnt("rstw_cnt", 2);
        tbr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (iocs && !iorw && ioaddr == 2'b00) break;
        end
        chk_val("rstw_wr", 32'(iocs && !iorw), 1);
        rst = 1'b1;
        @(negedge clk); #1;
        chk_val("rstw_cs", 32'(iocs), 0);
        chk_val("rstw_bus", 32'(bus_released()), 1);
        chk_val("rstw_cnt", 32'(fifo_count), 0);
        chk_val("rstw_done", 32'(init_done), 0);
        rst = 1'b0;
        wait_init("rstw_init", 1'b1);

        // Randomized traffic
        for (int it = 0; it < 600; it++) begin
            @(negedge clk); #1;
            tbr    = ($urandom_range(0, 3) != 0);
            rda_en = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0 && rx_n < 250) offer(8'($urandom));
            if ($urandom_range(0, 80) == 0) br_cfg = 2'($urandom);
        end

        rda_en = 1'b1; tbr = 1'b1;
        wait_drained("final_drain");
        wait_cnt("final_cnt", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
